seq_gen_prog: RTL

Parametrised, run-time programmable sequence generator. A Moore-style step machine walks a table of `DEPTH` steps. Each step holds an output value plus two successor indices, and the `ctrl` input picks the successor at every enabled step. The block sits wherever the design needs a repeating code sequence (display patterns, test stimulus, ALU op streams) that can be changed without resynthesis. It adds step enable, synchronous restart, a wrap flag and a table write port.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_table.sv | 39 +++
 rtl/seq_gen_prog.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the programmable sequence generator.
// Provides the default width/depth, the packed table entry and the
// function that produces an entry's reset contents.
package seq_pkg;

    localparam int unsigned SEQ_W     = 4;
    localparam int unsigned SEQ_DEPTH = 16;
    localparam int unsigned SEQ_AW    = $clog2(SEQ_DEPTH);

    // One step of the sequence: emitted value plus the two successors.
    typedef struct packed {
        logic [SEQ_W-1:0]  val;
        logic [SEQ_AW-1:0] next;
        logic [SEQ_AW-1:0] alt;
    } seq_entry_t;

    // Reset contents of entry i: zero value, both successors point to i+1 (wrapping).
    function automatic seq_entry_t seq_default(input int unsigned i,
                                               input int unsigned depth = SEQ_DEPTH);
        seq_entry_t  e;
        int unsigned n;
        n      = (i + 1) % depth;
        e.val  = '0;
        e.next = SEQ_AW'(n);
        e.alt  = SEQ_AW'(n);
        return e;
    endfunction

endpackage

// File: rtl/seq_table.sv
// Step table register file for seq_gen_prog.
// Ports:
//   clk, rst        clock, async active-low reset (loads seq_default per entry)
//   wr_en/wr_addr   write strobe and entry address (addresses >= DEPTH ignored)
//   wr_ent          entry payload written at the edge
//   rd_addr         read index (current step)
//   rd_ent_c        combinational read data (pre-edge contents)
module seq_table
    import seq_pkg::*;
#(
    parameter  int unsigned DEPTH = SEQ_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  seq_entry_t    wr_ent,
    input  logic [AW-1:0] rd_addr,
    output seq_entry_t    rd_ent_c
);

    seq_entry_t tbl_q [DEPTH];

    // Table storage; reset restores the linear default walk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= seq_default(i, DEPTH);
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            tbl_q[wr_addr] <= wr_ent;
        end
    end

    // Read returns the contents before any same-edge write.
    assign rd_ent_c = tbl_q[rd_addr];

endmodule

// File: rtl/seq_gen_prog.sv
// Run-time programmable sequence generator.
// Walks a DEPTH-entry step table; each enabled step emits the value of the
// step being left and moves to next/alt chosen by ctrl.
// Ports:
//   clk, rst                 clock, async active-low reset
//   en, clr, ctrl            step enable, sync restart (priority), successor select
//   wr_en, wr_addr, wr_val,
//   wr_next, wr_alt          table write port
//   sal                      registered value of the previously left step
//   idx                      current step index
//   wrap                     one-cycle pulse when an enabled step lands on 0
// W and the derived index width must match the seq_pkg entry layout.
module seq_gen_prog
    import seq_pkg::*;
#(
    parameter  int unsigned W     = SEQ_W,
    parameter  int unsigned DEPTH = SEQ_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          ctrl,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_val,
    input  logic [AW-1:0] wr_next,
    input  logic [AW-1:0] wr_alt,
    output logic [W-1:0]  sal,
    output logic [AW-1:0] idx,
    output logic          wrap
);

    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  sal_q, sal_d;
    logic          wrap_q, wrap_d;

    seq_entry_t        wr_ent_c;
    seq_entry_t        cur_c;
    logic [SEQ_AW-1:0] succ_raw_c;
    logic [AW-1:0]     succ_c;

    // Pack the write port into a table entry.
    always_comb begin
        wr_ent_c      = '0;
        wr_ent_c.val  = SEQ_W'(wr_val);
        wr_ent_c.next = SEQ_AW'(wr_next);
        wr_ent_c.alt  = SEQ_AW'(wr_alt);
    end

    seq_table #(
        .DEPTH    (DEPTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_ent   (wr_ent_c),
        .rd_addr  (idx_q),
        .rd_ent_c (cur_c)
    );

    // Successor select; indices past the table end fold to entry 0.
    always_comb begin
        succ_raw_c = ctrl ? cur_c.alt : cur_c.next;
        succ_c     = (32'(succ_raw_c) >= DEPTH) ? '0 : AW'(succ_raw_c);
    end

    // Step control: clr beats en; wrap is a single-cycle pulse.
    always_comb begin
        idx_d  = idx_q;
        sal_d  = sal_q;
        wrap_d = 1'b0;
        if (clr) begin
            idx_d = '0;
            sal_d = '0;
        end else if (en) begin
            sal_d  = W'(cur_c.val);
            idx_d  = succ_c;
            wrap_d = (succ_c == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            sal_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            sal_q  <= sal_d;
            wrap_q <= wrap_d;
        end
    end

    assign sal  = sal_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
